cpu_ctrl_fsm: RTL and testbench



---
 rtl/cpu_ctrl_fsm.sv | 207 ++++++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the RV32I subset datapath
module cpu_ctrl_fsm #(
  parameter int COUNT_W     = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               pc_we,
  output logic               ir_we,
  output logic               reg_we,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         wb_sel,
  output logic               pc_src,
  output logic [2:0]         state,
  output logic               halted,
  output logic               bus_err,
  output logic [COUNT_W-1:0] instr_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam int              WAIT_W     = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [6:0]          r_opcode;
  logic [2:0]          r_funct3;
  logic [WAIT_W-1:0]   r_wait;
  logic [COUNT_W-1:0]  r_count;
  logic                r_halted;
  logic                r_bus_err;
  logic                w_retire;
  logic                w_timeout;
  logic                w_wait_limit;
  logic                w_supported;

  assign state       = r_state;
  assign halted      = r_halted;
  assign bus_err     = r_bus_err;
  assign instr_count = r_count;

  // The last waiting cycle is the one that would bring the counter to the limit.
  assign w_wait_limit = (MEM_TIMEOUT != 0) && (r_wait == WAIT_LIMIT);

  always_comb begin
    w_supported = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_JAL, OP_LUI: w_supported = 1'b1;
      OP_BRANCH: w_supported = (funct3 == 3'b000) || (funct3 == 3'b001);
      default:   w_supported = 1'b0;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    alu_op    = 2'd0;
    wb_sel    = 2'd0;
    pc_src    = 1'b0;
    w_next    = r_state;
    w_retire  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd2;
        if (mem_ready) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          w_next = S_DECODE;
        end else if (w_wait_limit) begin
          w_next    = S_HALT;
          w_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd1;
        w_next    = w_supported ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        case (r_opcode)
          OP_R: begin
            alu_src_a = 2'd1;
            alu_op    = 2'd2;
            w_next    = S_WB;
          end
          OP_I: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd1;
            alu_op    = 2'd2;
            w_next    = S_WB;
          end
          OP_LUI: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd1;
            w_next    = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd1;
            w_next    = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a = 2'd1;
            alu_op    = 2'd1;
            pc_src    = 1'b1;
            pc_we     = (r_funct3 == 3'b000) ? zero : ~zero;
            w_next    = S_FETCH;
            w_retire  = 1'b1;
          end
          OP_JAL: begin
            pc_we    = 1'b1;
            pc_src   = 1'b1;
            reg_we   = 1'b1;
            wb_sel   = 2'd2;
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
          default: w_next = S_HALT;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (r_opcode == OP_STORE);
        if (mem_ready) begin
          if (r_opcode == OP_STORE) begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end else begin
            w_next = S_WB;
          end
        end else if (w_wait_limit) begin
          w_next    = S_HALT;
          w_timeout = 1'b1;
        end
      end
      S_WB: begin
        reg_we   = 1'b1;
        wb_sel   = (r_opcode == OP_LOAD) ? 2'd1 : 2'd0;
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_opcode  <= 7'd0;
      r_funct3  <= 3'd0;
      r_wait    <= '0;
      r_count   <= '0;
      r_halted  <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_opcode <= opcode;
        r_funct3 <= funct3;
      end
      if (w_retire)            r_count   <= r_count + 1'b1;
      if (w_next == S_HALT)    r_halted  <= 1'b1;
      if (w_timeout)           r_bus_err <= 1'b1;
      if (w_next != r_state)   r_wait    <= '0;
      else if (mem_req && !mem_ready) r_wait <= r_wait + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - self-checking bench for cpu_ctrl_fsm
module tb_cpu_ctrl_fsm;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, pc_we, ir_we, reg_we, pc_src, halted, bus_err;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, wb_sel;
  logic [2:0]  state;
  logic [31:0] instr_count;

  cpu_ctrl_fsm #(.COUNT_W(32), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .pc_we(pc_we),
    .ir_we(ir_we), .reg_we(reg_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .wb_sel(wb_sel), .pc_src(pc_src), .state(state),
    .halted(halted), .bus_err(bus_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_count;

  // Observations from the most recent run_instr call.
  int          trace[$];
  logic [1:0]  x_a, x_b, x_op, d_a, d_b, d_op, f_b;
  logic        x_pcwe, x_pcsrc;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    logic [1:0] a, b, aop;
    logic       pcwe, pcsrc;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clock: drive mem_ready just after the edge, caller samples at the falling edge.
  task automatic half(input logic rdy);
    mem_ready = rdy;
    @(negedge clk);
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: an instruction is a fixed sequence of phases whose length and
  // strobe totals follow from its class and the two memory delays.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                           input int df, input int dm, input string tag);
    bit is_mem  = (op == OP_LOAD) || (op == OP_STORE);
    bit is_wb   = (op == OP_R) || (op == OP_I) || (op == OP_LUI) || (op == OP_LOAD);
    bit is_br   = (op == OP_BRANCH);
    bit taken   = is_br && ((f3 == 3'b000) ? z : !z);
    int len     = df + 3 + (is_mem ? dm + 1 : 0) + (is_wb ? 1 : 0);
    int e_req   = df + 1 + (is_mem ? dm + 1 : 0);
    int e_we    = (op == OP_STORE) ? dm + 1 : 0;
    int e_pcwe  = 1 + ((op == OP_JAL) ? 1 : 0) + (taken ? 1 : 0);
    int e_regwe = (is_wb || op == OP_JAL) ? 1 : 0;
    int e_wbsel = (op == OP_LOAD) ? 1 : (op == OP_JAL) ? 2 : 0;
    int n_req = 0, n_we = 0, n_pcwe = 0, n_irwe = 0, n_regwe = 0, seen_wbsel = 0;
    logic rdy;
    opcode = op;
    funct3 = f3;
    zero   = z;
    trace.delete();
    for (int c = 0; c < len; c++) begin
      if (c <= df)                                 rdy = (c == df);
      else if (is_mem && c >= df + 3 && c <= df + 3 + dm) rdy = (c == df + 3 + dm);
      else                                         rdy = 1'($urandom_range(0, 1));
      half(rdy);
      trace.push_back(int'(state));
      n_req   += int'(mem_req);
      n_we    += int'(mem_we);
      n_pcwe  += int'(pc_we);
      n_irwe  += int'(ir_we);
      n_regwe += int'(reg_we);
      if (reg_we) seen_wbsel = int'(wb_sel);
      if (c == 0)      f_b = alu_src_b;
      if (c == df + 1) begin d_a = alu_src_a; d_b = alu_src_b; d_op = alu_op; end
      if (c == df + 2) begin
        x_a = alu_src_a; x_b = alu_src_b; x_op = alu_op; x_pcwe = pc_we; x_pcsrc = pc_src;
      end
      finish_cycle();
    end
    exp_count = exp_count + 1;
    chk({tag, " back_to_fetch"}, 64'(state), 64'd0);
    chk({tag, " instr_count"}, 64'(instr_count), 64'(exp_count));
    chk({tag, " mem_req_cycles"}, 64'(n_req), 64'(e_req));
    chk({tag, " mem_we_cycles"}, 64'(n_we), 64'(e_we));
    chk({tag, " pc_we_cycles"}, 64'(n_pcwe), 64'(e_pcwe));
    chk({tag, " ir_we_cycles"}, 64'(n_irwe), 64'd1);
    chk({tag, " reg_we_cycles"}, 64'(n_regwe), 64'(e_regwe));
    if (e_regwe != 0) chk({tag, " wb_sel"}, 64'(seen_wbsel), 64'(e_wbsel));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    half(1'b1);
    chk({tag, " rst_mem_req"}, 64'(mem_req), 64'd0);
    chk({tag, " rst_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, " rst_strobes"}, 64'({pc_we, ir_we, reg_we}), 64'd0);
    finish_cycle();
    rst = 1'b0;
    exp_count = '0;
    chk({tag, " reset_state"}, 64'(state), 64'd0);
    chk({tag, " reset_count"}, 64'(instr_count), 64'd0);
    chk({tag, " reset_flags"}, 64'({halted, bus_err}), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int   n_mem_req;
    int   n_mem_we;
    logic [6:0] kinds[7];
    vecs[0] = '{OP_R,      3'b000, 1'b0, 2'd1, 2'd0, 2'd2, 1'b0, 1'b0};
    vecs[1] = '{OP_I,      3'b110, 1'b1, 2'd1, 2'd1, 2'd2, 1'b0, 1'b0};
    vecs[2] = '{OP_LUI,    3'b000, 1'b0, 2'd2, 2'd1, 2'd0, 1'b0, 1'b0};
    vecs[3] = '{OP_LOAD,   3'b010, 1'b0, 2'd1, 2'd1, 2'd0, 1'b0, 1'b0};
    vecs[4] = '{OP_STORE,  3'b010, 1'b1, 2'd1, 2'd1, 2'd0, 1'b0, 1'b0};
    vecs[5] = '{OP_BRANCH, 3'b000, 1'b1, 2'd1, 2'd0, 2'd1, 1'b1, 1'b1};
    vecs[6] = '{OP_BRANCH, 3'b000, 1'b0, 2'd1, 2'd0, 2'd1, 1'b0, 1'b1};
    vecs[7] = '{OP_BRANCH, 3'b001, 1'b1, 2'd1, 2'd0, 2'd1, 1'b0, 1'b1};
    vecs[8] = '{OP_BRANCH, 3'b001, 1'b0, 2'd1, 2'd0, 2'd1, 1'b1, 1'b1};
    vecs[9] = '{OP_JAL,    3'b000, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1};
    kinds = '{OP_R, OP_I, OP_LUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};

    rst = 1'b1; opcode = OP_R; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b0;
    exp_count = '0;
    @(posedge clk);
    #1;
    do_reset("init");

    // Table: per-class EXEC selects plus whole-instruction totals.
    for (int i = 0; i < 10; i++) begin
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].z, 0, 0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d fetch_b", i), 64'(f_b), 64'd2);
      chk($sformatf("vec%0d decode_sel", i), 64'({d_a, d_b, d_op}), 64'({2'd0, 2'd1, 2'd0}));
      chk($sformatf("vec%0d exec_sel", i), 64'({x_a, x_b, x_op}), 64'({vecs[i].a, vecs[i].b, vecs[i].aop}));
      chk($sformatf("vec%0d exec_pc", i), 64'({x_pcwe, x_pcsrc}), 64'({vecs[i].pcwe, vecs[i].pcsrc}));
    end

    // ADD state trace 0,1,2,4; LW with 3 wait cycles 0,1,2,3,3,3,3,4.
    run_instr(OP_R, 3'b000, 1'b0, 0, 0, "add_trace");
    chk("add_trace len", 64'(trace.size()), 64'd4);
    if (trace.size() == 4)
      chk("add_trace seq", 64'({trace[0][3:0], trace[1][3:0], trace[2][3:0], trace[3][3:0]}), 64'(16'h0124));
    run_instr(OP_LOAD, 3'b010, 1'b0, 0, 3, "lw_delay3");
    chk("lw_delay3 len", 64'(trace.size()), 64'd8);
    if (trace.size() == 8)
      chk("lw_delay3 seq", 64'({trace[0][3:0], trace[1][3:0], trace[2][3:0], trace[3][3:0],
                                trace[4][3:0], trace[5][3:0], trace[6][3:0], trace[7][3:0]}), 64'(32'h01233334));

    // Ready on the very cycle the wait limit is reached must win.
    run_instr(OP_STORE, 3'b010, 1'b0, 15, 15, "edge_ready");
    chk("edge_ready no_bus_err", 64'({halted, bus_err}), 64'd0);

    // Randomized instruction stream.
    for (int i = 0; i < 40; i++) begin
      logic [6:0] op;
      logic [2:0] f3;
      op = kinds[$urandom_range(0, 6)];
      f3 = (op == OP_BRANCH) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      run_instr(op, f3, 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4),
                $sformatf("rnd%0d", i));
    end

    // Unsupported opcode halts from DECODE and stays quiet.
    opcode = 7'b1111111;
    half(1'b1); finish_cycle();
    half(1'b1);
    chk("illegal decode_state", 64'(state), 64'd1);
    finish_cycle();
    n_mem_req = 0;
    for (int c = 0; c < 20; c++) begin
      half(1'($urandom_range(0, 1)));
      n_mem_req += int'(mem_req);
      finish_cycle();
    end
    chk("illegal state", 64'(state), 64'd5);
    chk("illegal flags", 64'({halted, bus_err}), 64'({1'b1, 1'b0}));
    chk("illegal mem_req", 64'(n_mem_req), 64'd0);
    chk("illegal count", 64'(instr_count), 64'(exp_count));
    do_reset("after_illegal");

    // Branch with a funct3 outside BEQ/BNE also halts.
    opcode = OP_BRANCH; funct3 = 3'b100;
    half(1'b1); finish_cycle();
    half(1'b0); finish_cycle();
    chk("bad_branch state", 64'(state), 64'd5);
    chk("bad_branch flags", 64'({halted, bus_err}), 64'({1'b1, 1'b0}));
    do_reset("after_bad_branch");

    // Store that never completes: 16 MEM cycles then bus error.
    run_instr(OP_R, 3'b000, 1'b0, 0, 0, "pre_timeout");
    opcode = OP_STORE; funct3 = 3'b010;
    half(1'b1); finish_cycle();
    half(1'b0); finish_cycle();
    half(1'b0); finish_cycle();
    n_mem_we = 0;
    for (int c = 0; c < 20; c++) begin
      half(1'b0);
      n_mem_we += int'(mem_we);
      finish_cycle();
    end
    chk("timeout mem_we_cycles", 64'(n_mem_we), 64'd16);
    chk("timeout state", 64'(state), 64'd5);
    chk("timeout flags", 64'({halted, bus_err}), 64'({1'b1, 1'b1}));
    chk("timeout count", 64'(instr_count), 64'(exp_count));
    do_reset("after_timeout");

    // Fetch that never completes also times out.
    n_mem_req = 0;
    for (int c = 0; c < 18; c++) begin
      half(1'b0);
      n_mem_req += int'(mem_req);
      finish_cycle();
    end
    chk("fetch_timeout mem_req_cycles", 64'(n_mem_req), 64'd16);
    chk("fetch_timeout flags", 64'({state, halted, bus_err}), 64'({3'd5, 1'b1, 1'b1}));
    do_reset("after_fetch_timeout");

    // Reset pulse in the middle of a store's MEM phase.
    run_instr(OP_I, 3'b000, 1'b0, 0, 0, "pre_abort");
    opcode = OP_STORE;
    half(1'b1); finish_cycle();
    half(1'b0); finish_cycle();
    half(1'b0); finish_cycle();
    half(1'b0);
    chk("abort in_mem", 64'({state, mem_we}), 64'({3'd3, 1'b1}));
    finish_cycle();
    do_reset("abort");
    half(1'b0);
    chk("abort no_mem_we", 64'({mem_we, mem_req}), 64'({1'b0, 1'b1}));
    finish_cycle();
    run_instr(OP_R, 3'b000, 1'b0, 0, 0, "post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
